fft_sample_loader: RTL
======================

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 Parameter: width, 16, bits per real/imag component.
REQ-002 Parameter: M, 5, log2 of FFT length N=2^M.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sample_in  input  width  signed real sample from the audio front end.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 sample_ready  output  1  loader accepts a sample this cycle.
REQ-008 load  output  1  FFT RAM0 load strobe.
REQ-009 rd_adr  output  M  natural-order load index; the FFT applies bit reversal.
REQ-010 rd  output  2*width  load data {re, im}.
REQ-011 start  output  1  one-cycle FFT start pulse.
REQ-012 fft_reset  output  1  synchronous clear of FFT control and AGU.
REQ-013 fft_done  input  1  FFT finished; held high while results are read out.
REQ-014 result_valid  output  1  the FFT output word is valid this cycle.
REQ-015 result_idx  output  M  bin index of the current output word.
REQ-016 drop_count  output  16  saturating count of samples offered while not ready.

Function
REQ-017 FSM states: CLEAR, LOAD, START, RUN, UNLOAD.
REQ-018 CLEAR: fft_reset=1 for exactly one cycle; next state is LOAD; sample counter and result_idx are cleared to 0.
REQ-019 LOAD: sample_ready=1. A sample is accepted when sample_valid&sample_ready.
REQ-020 Each accepted sample produces, in the next cycle, load=1, rd_adr=sample count, rd={sample_in, width'b0}; load, rd and rd_adr are registered.
REQ-021 The sample count increments per accepted sample. An accept at count N-1 moves the FSM to START and deasserts sample_ready in the following cycle.
REQ-022 START: start=1 for one cycle; load=1 is still asserted for the final sample in this same cycle; next state is RUN.
REQ-023 RUN: sample_ready=0; the FSM waits for fft_done=1. On that cycle it moves to UNLOAD.
REQ-024 UNLOAD: result_valid=1 and result_idx counts 0..N-1 once per cycle, in step with the FFT output counter. After the cycle with result_idx=N-1, the next state is CLEAR.
REQ-025 The first UNLOAD cycle aligns with the FFT output index 0, which is the first cycle after fft_done rises.
REQ-026 The sample counter and result_idx wrap modulo N; they never exceed N-1.
REQ-027 sample_valid=1 with sample_ready=0 increments drop_count by 1. drop_count saturates at 0xFFFF and is never cleared except by reset.
REQ-028 load and start are never asserted in CLEAR, RUN or UNLOAD. Exception: the final load overlaps START, as stated in REQ-022.
REQ-029 fft_done=1 outside RUN and UNLOAD is ignored.
REQ-030 If fft_done deasserts during UNLOAD, the FSM still completes all N result cycles.
REQ-031 One full frame takes: 1 CLEAR cycle + ≥N LOAD cycles + 1 START cycle + FFT run + N UNLOAD cycles.

Reset
REQ-032 fft_reset = reset OR (state==CLEAR), so the FFT is cleared together with the loader.
REQ-033 On reset: state=CLEAR. sample_ready, load, start, result_valid = 0. rd_adr, rd, result_idx, sample count, drop_count = 0.
REQ-034 Reset asserted mid-frame, in any state, discards the partial frame. The next frame restarts at rd_adr=0.

Verification
REQ-035 Continuous valid, N=32, samples 0..31 -> load on 32 consecutive cycles, rd_adr 0..31, rd[2w-1:w]=k, rd[w-1:0]=0. start is high in the same cycle as the rd_adr=31 load.
REQ-036 sample_valid toggled every other cycle -> exactly one load per accept, no gaps in rd_adr, start only after the 32nd accept.
REQ-037 Model fft_done rising 170 cycles after start -> result_valid high for exactly 32 cycles, result_idx 0..31. Then fft_reset pulses once and sample_ready returns.
REQ-038 Valid held during RUN for 100 cycles -> drop_count=100. Force drop_count to 0xFFFE with 5 more drops -> stays at 0xFFFF.
REQ-039 Reset after 10 accepted samples -> all outputs 0. The next frame's first load has rd_adr=0 and fft_reset is seen high.
REQ-040 fft_done pulsed during LOAD -> no state change, and the load sequence is unaffected.

Source files
------------

// File: rtl/fft_sample_loader_if.sv
// Handshake and FFT-control bundle between the sample loader and its environment.
// The master side is the loader; the slave side is the audio front end plus the FFT core.
interface fft_sample_loader_if #(
    parameter int unsigned width = 16,
    parameter int unsigned M     = 5
);
    logic signed [width-1:0] sample_in;
    logic                    sample_valid;
    logic                    sample_ready;
    logic                    load;
    logic [M-1:0]            rd_adr;
    logic [2*width-1:0]      rd;
    logic                    start;
    logic                    fft_reset;
    logic                    fft_done;
    logic                    result_valid;
    logic [M-1:0]            result_idx;
    logic [15:0]             drop_count;

    modport master (
        input  sample_in, sample_valid, fft_done,
        output sample_ready, load, rd_adr, rd, start, fft_reset,
               result_valid, result_idx, drop_count
    );

    modport slave (
        output sample_in, sample_valid, fft_done,
        input  sample_ready, load, rd_adr, rd, start, fft_reset,
               result_valid, result_idx, drop_count
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Collects N real samples into FFT RAM0, kicks off the FFT, then tracks the result readout.
// Samples offered while the loader is busy are counted in a saturating drop counter.
module fft_sample_loader #(
    parameter int unsigned width = 16,
    parameter int unsigned M     = 5
) (
    input logic                 clk,
    input logic                 reset,
    fft_sample_loader_if.master bus
);
    localparam int unsigned N = 1 << M;
    localparam logic [M-1:0] LastIdx = M'(N - 1);

    typedef enum logic [2:0] {StClear, StLoad, StStart, StRun, StUnload} state_e;

    state_e             state_q, state_d;
    logic [M-1:0]       count_q, count_d;
    logic [M-1:0]       idx_q, idx_d;
    logic               load_q;
    logic [M-1:0]       adr_q;
    logic [2*width-1:0] rd_q;
    logic [15:0]        drop_q;
    logic               ready;
    logic               start;
    logic               unloading;
    logic               accept;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        ready     = 1'b0;
        start     = 1'b0;
        unloading = 1'b0;
        unique case (state_q)
            StClear: begin
                count_d = '0;
                idx_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                ready = 1'b1;
                if (bus.sample_valid) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LastIdx) state_d = StStart;
                end
            end
            StStart: begin
                start   = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (bus.fft_done) state_d = StUnload;
            end
            StUnload: begin
                // Runs all N bins regardless of fft_done once started.
                unloading = 1'b1;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LastIdx) state_d = StClear;
            end
            default: state_d = StClear;
        endcase
    end

    assign accept = bus.sample_valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            count_q <= '0;
            idx_q   <= '0;
            load_q  <= 1'b0;
            adr_q   <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            load_q  <= accept;
            if (accept) begin
                adr_q <= count_q;
                rd_q  <= {bus.sample_in, {width{1'b0}}};
            end
            if (bus.sample_valid && !ready && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign bus.sample_ready = ready;
    assign bus.load         = load_q;
    assign bus.rd_adr       = adr_q;
    assign bus.rd           = rd_q;
    assign bus.start        = start;
    assign bus.fft_reset    = reset | (state_q == StClear);
    assign bus.result_valid = unloading;
    assign bus.result_idx   = idx_q;
    assign bus.drop_count   = drop_q;
endmodule
